input_sequencer: RTL and testbench
==================================

INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of stable clock cycles required before a button level is accepted (10 ms at 50 MHz).
REQ-002 Parameter W, default 8, is the operand width.
REQ-003 Port clock, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port buttons, input, 2: raw pushbuttons, active-low, asynchronous to clock. Bit 0 = advance; bit 1 = clear.
REQ-006 Port switches, input, 10: raw slide switches, used as the capture source.
REQ-007 Port operand_a, output, W: captured first operand.
REQ-008 Port operand_b, output, W: captured second operand.
REQ-009 Port op_sel, output, 2: captured result-select code for the downstream multiplexer.
REQ-010 Port mode, output, 2: captured operation mode for the arithmetic, logical and comparison units.
REQ-011 Port state, output, 2: current FSM state, for LED display.
REQ-012 Port valid, output, 1: one-cycle pulse that marks a complete, newly captured operand set.

Function
REQ-013 Each button SHALL pass through a 2-flip-flop synchronizer before any other use.
REQ-014 Debounce: the block SHALL keep one counter per button; the counter clears whenever the synchronized level equals the debounced level.
REQ-015 The debounced level SHALL take the synchronized value when the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present.
REQ-016 Debounce latency from a stable raw edge to a debounced edge SHALL be DEBOUNCE_CYCLES+2 cycles; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no debounced change.
REQ-017 A press pulse SHALL be a one-cycle strobe on the debounced 1->0 transition.
REQ-018 Holding a button SHALL produce exactly one pulse; the button must be released and pressed again for a further pulse.
REQ-019 FSM states, 2-bit encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3.
REQ-020 LOAD_A, advance pulse: operand_a <= switches[W-1:0]; next state LOAD_B.
REQ-021 LOAD_B, advance pulse: operand_b <= switches[W-1:0]; next state LOAD_OP.
REQ-022 LOAD_OP, advance pulse: op_sel <= switches[1:0], mode <= switches[9:8]; next state READY; valid=1 for that same cycle (registered, coincident with the state change).
REQ-023 READY, advance pulse: next state LOAD_A; no capture; all outputs hold their values until overwritten.
REQ-024 Clear pulse in any state: operand_a, operand_b, op_sel and mode SHALL go to 0, next state LOAD_A, valid=0.
REQ-025 If advance and clear pulses occur in the same cycle, clear SHALL win and advance SHALL be ignored.
REQ-026 Switch values SHALL be sampled only in the capture cycle; switch changes at any other time SHALL have no effect on the outputs.
REQ-027 valid SHALL never be high for two consecutive cycles.
REQ-028 All outputs SHALL be driven directly from registers, with no combinational path from the inputs.

Reset
REQ-029 When reset_n=0, the block SHALL asynchronously set state=LOAD_A, all operands, op_sel and mode to 0, valid=0 and the debounce counters to 0.
REQ-030 During reset, debounced levels and synchronizer flops SHALL be 1 (released).
REQ-031 Reset asserted mid-capture SHALL discard the partial operand set; no valid pulse follows.
REQ-032 Reset release SHALL be synchronized to clock, so the first state change occurs no earlier than the second clock edge after release.

Structure
REQ-033 A shared package SHALL hold the state typedef/encoding, W and the DEBOUNCE_CYCLES default.
REQ-034 Sub-module debouncer (synchronizer, counter and press-pulse generator) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4)
REQ-035 Scenario 1: press advance three times with switches at 0x35, then 0x0C, then 0x2C2 -> operand_a=0x35, operand_b=0x0C, op_sel=2, mode=2, valid high for exactly one cycle, state=3.
REQ-036 Scenario 2: a 3-cycle low glitch on buttons[0] -> no pulse; state unchanged.
REQ-037 Scenario 3: hold buttons[0] low for 100 cycles -> exactly one advance (state 0->1).
REQ-038 Scenario 4: advance and clear released to low on the same cycle while in LOAD_OP -> state=0, all outputs 0, no valid pulse.
REQ-039 Scenario 5: reset_n pulsed low in LOAD_B -> outputs 0 immediately (asynchronous), state=0; switches then toggled with no press -> outputs stay 0.
REQ-040 Scenario 6: advance in READY -> state=0, operands held; a new advance with switches=0xFF -> operand_a=0xFF, operand_b unchanged.

Source files
------------

// File: rtl/input_sequencer_pkg.sv
// Shared types and defaults for the pushbutton/switch operand sequencer.
// Holds the FSM state encoding, operand width and debounce length defaults.
package input_sequencer_pkg;

   localparam int SEQ_W               = 8;
   localparam int SEQ_DEBOUNCE_CYCLES = 500000;
   localparam int SEQ_SW_W            = 10;
   localparam int SEQ_NUM_BTN         = 2;

   // Button roles inside the buttons[] vector
   localparam int BTN_ADVANCE = 0;
   localparam int BTN_CLEAR   = 1;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      READY   = 2'd3
   } seq_state_t;

   // Counter width able to hold n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/input_sequencer_debouncer.sv
// Synchronizes and debounces one active-low button and emits a 1-cycle press strobe.
// Latency: raw edge to debounced edge DEBOUNCE_CYCLES+2 cycles, strobe registered on that edge; no backpressure.
module input_sequencer_debouncer
   import input_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SEQ_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // Released (1) is the safe idle value for both the synchronizer and the debounced level
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
            press <= level & ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_sequencer.sv
// Steps through A, B, OP capture from slide switches on debounced advance presses; clear resets the set.
// Latency: outputs update one cycle after a press strobe; valid pulses with the OP capture; no backpressure.
module input_sequencer
   import input_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SEQ_DEBOUNCE_CYCLES,
   parameter int W               = SEQ_W
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [1:0]          buttons,
   input  logic [SEQ_SW_W-1:0] switches,
   output logic [W-1:0]        operand_a,
   output logic [W-1:0]        operand_b,
   output logic [1:0]          op_sel,
   output logic [1:0]          mode,
   output logic [1:0]          state,
   output logic                valid
);

   logic                   rst_meta;
   logic                   rst_n;
   logic [SEQ_NUM_BTN-1:0] press;
   seq_state_t             cur;

   // Assert asynchronously, release two edges later so no flop sees a partial release
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   for (genvar i = 0; i < SEQ_NUM_BTN; i++) begin : g_btn
      input_sequencer_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clock (clock),
         .rst_n (rst_n),
         .btn   (buttons[i]),
         .press (press[i])
      );
   end

   assign state = cur;

   // Clear takes priority over a coincident advance
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= LOAD_A;
         operand_a <= '0;
         operand_b <= '0;
         op_sel    <= '0;
         mode      <= '0;
         valid     <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (press[BTN_CLEAR]) begin
            cur       <= LOAD_A;
            operand_a <= '0;
            operand_b <= '0;
            op_sel    <= '0;
            mode      <= '0;
         end else if (press[BTN_ADVANCE]) begin
            case (cur)
               LOAD_A: begin
                  operand_a <= switches[W-1:0];
                  cur       <= LOAD_B;
               end
               LOAD_B: begin
                  operand_b <= switches[W-1:0];
                  cur       <= LOAD_OP;
               end
               LOAD_OP: begin
                  op_sel <= switches[1:0];
                  mode   <= switches[SEQ_SW_W-1:SEQ_SW_W-2];
                  valid  <= 1'b1;
                  cur    <= READY;
               end
               READY: begin
                  cur <= LOAD_A;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_input_sequencer.sv
// Directed bench with a scoreboard queue of expected operand sets checked on each valid pulse.
module tb_input_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [1:0] buttons;
   logic [9:0] switches;
   logic [7:0] operand_a;
   logic [7:0] operand_b;
   logic [1:0] op_sel;
   logic [1:0] mode;
   logic [1:0] state;
   logic       valid;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
      logic [1:0] md;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   logic prev_valid = 1'b0;

   input_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .W(8)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .buttons   (buttons),
      .switches  (switches),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .op_sel    (op_sel),
      .mode      (mode),
      .state     (state),
      .valid     (valid)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic [7:0] a,
                            input logic [7:0] b, input logic [1:0] op, input logic [1:0] md);
      check({tag, "_state"}, 32'(state), 32'(st));
      check({tag, "_a"}, 32'(operand_a), 32'(a));
      check({tag, "_b"}, 32'(operand_b), 32'(b));
      check({tag, "_op"}, 32'(op_sel), 32'(op));
      check({tag, "_mode"}, 32'(mode), 32'(md));
   endtask

   // Drive the given button mask low for 'hold' edges, then release and let the debouncer settle
   task automatic push(input logic [1:0] mask, input int hold);
      @(posedge clock);
      #1 buttons = ~mask;
      repeat (hold) @(posedge clock);
      #1 buttons = 2'b11;
      repeat (14) @(posedge clock);
      @(negedge clock);
   endtask

   // Monitor: every valid pulse must match the next queued operand set
   always @(negedge clock) begin
      if (valid) begin
         check("valid_single_cycle", 32'(prev_valid), 32'd0);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got valid=1 with a=0x%0h b=0x%0h, expected no pulse",
                     operand_a, operand_b);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_a", 32'(operand_a), 32'(e.a));
            check("sb_b", 32'(operand_b), 32'(e.b));
            check("sb_op", 32'(op_sel), 32'(e.op));
            check("sb_mode", 32'(mode), 32'(e.md));
            check("sb_state", 32'(state), 32'd3);
         end
      end
      prev_valid = valid;
   end

   initial begin
      buttons  = 2'b11;
      switches = 10'h000;
      reset_n  = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (4) @(posedge clock);
      @(negedge clock);
      check_all("reset", 2'd0, 8'h00, 8'h00, 2'd0, 2'd0);
      check("reset_valid", 32'(valid), 32'd0);

      // Glitch shorter than the debounce window
      @(posedge clock);
      #1 buttons[0] = 1'b0;
      repeat (3) @(posedge clock);
      #1 buttons[0] = 1'b1;
      repeat (16) @(posedge clock);
      @(negedge clock);
      check("glitch_state", 32'(state), 32'd0);

      // Long hold yields exactly one advance
      switches = 10'h0A5;
      push(2'b01, 100);
      check("hold_state", 32'(state), 32'd1);
      check("hold_a", 32'(operand_a), 32'hA5);

      push(2'b10, 10);
      check_all("clear", 2'd0, 8'h00, 8'h00, 2'd0, 2'd0);

      // Full capture sequence
      switches = 10'h035;
      push(2'b01, 10);
      check("s1_state_a", 32'(state), 32'd1);
      switches = 10'h00C;
      push(2'b01, 10);
      check("s1_state_b", 32'(state), 32'd2);
      sb.push_back('{a: 8'h35, b: 8'h0C, op: 2'd2, md: 2'd2});
      switches = 10'h2C2;
      push(2'b01, 10);
      check_all("s1", 2'd3, 8'h35, 8'h0C, 2'd2, 2'd2);
      check("s1_valid_low", 32'(valid), 32'd0);

      // Switch changes outside a capture cycle are ignored
      switches = 10'h3FF;
      repeat (6) @(negedge clock);
      check_all("sw_ignored", 2'd3, 8'h35, 8'h0C, 2'd2, 2'd2);

      // Advance in READY wraps without capture, then recaptures A only
      push(2'b01, 10);
      check_all("ready_wrap", 2'd0, 8'h35, 8'h0C, 2'd2, 2'd2);
      switches = 10'h0FF;
      push(2'b01, 10);
      check_all("recap_a", 2'd1, 8'hFF, 8'h0C, 2'd2, 2'd2);

      // Asynchronous reset in LOAD_B
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1 check_all("async_rst", 2'd0, 8'h00, 8'h00, 2'd0, 2'd0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1 switches = 10'(i * 10'h0AB);
      end
      @(negedge clock);
      check_all("post_rst", 2'd0, 8'h00, 8'h00, 2'd0, 2'd0);

      // Simultaneous advance and clear in LOAD_OP: clear wins, no valid
      switches = 10'h011;
      push(2'b01, 10);
      switches = 10'h022;
      push(2'b01, 10);
      check_all("pre_both", 2'd2, 8'h11, 8'h22, 2'd0, 2'd0);
      switches = 10'h3FF;
      push(2'b11, 10);
      check_all("both", 2'd0, 8'h00, 8'h00, 2'd0, 2'd0);

      repeat (4) @(negedge clock);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
